board_shuffler: RTL and testbench

BOARD_SHUFFLER -- requirements
Module: board_shuffler

---
 rtl/board_shuffler.sv | 115 +++++++++++
 tb/tb_board_shuffler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/board_shuffler.sv
// board_shuffler: fills a 16-entry tile RAM with 8 symbol pairs and Fisher-Yates shuffles it using an LFSR
module board_shuffler #(
  parameter logic [15:0] DEF_SEED = 16'hACE1
) (
  input  logic        pixelClk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] seed,
  output logic [3:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic        busy,
  output logic        done
);
  typedef enum logic [3:0] {IDLE, FILL, PICK, RD_I, RD_J, CAP_J, WR_I, WR_J, DONE} state_t;
  state_t state, state_n;
  logic [3:0] i, i_n, j, j_n, mask, pick, addr_n;
  logic [15:0] lfsr, lfsr_n;
  logic [7:0] tile_i, tile_i_n, wd_n;
  logic we_n;
  assign mask = i[3] ? 4'hF : i[2] ? 4'h7 : i[1] ? 4'h3 : 4'h1;
  assign pick = lfsr[3:0] & mask;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  // next state plus next values of the registered RAM port; RAM outputs are decided one cycle ahead
  always_comb begin
    state_n = state;
    i_n = i;
    j_n = j;
    lfsr_n = lfsr;
    tile_i_n = tile_i;
    we_n = 1'b0;
    addr_n = ram_addr;
    wd_n = ram_wdata;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = FILL;
        lfsr_n = seed == 16'd0 ? DEF_SEED : seed;
        i_n = 4'd0;
        we_n = 1'b1;
        addr_n = 4'd0;
        wd_n = 8'd0;
      end
      FILL: if (i == 4'd15) state_n = PICK;
      else begin
        i_n = i + 4'd1;
        we_n = 1'b1;
        addr_n = i + 4'd1;
        wd_n = {5'd0, addr_n[3:1]};
      end
      PICK: begin
        lfsr_n = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        j_n = pick;
        if (pick <= i) begin
          state_n = RD_I;
          addr_n = i;
        end
      end
      RD_I: begin
        state_n = RD_J;
        addr_n = j;
      end
      RD_J: begin
        state_n = CAP_J;
        tile_i_n = ram_rdata;
      end
      CAP_J: begin
        state_n = WR_I;
        we_n = 1'b1;
        addr_n = i;
        wd_n = ram_rdata;
      end
      WR_I: begin
        state_n = WR_J;
        we_n = 1'b1;
        addr_n = j;
        wd_n = tile_i;
      end
      WR_J: begin
        state_n = i == 4'd1 ? DONE : PICK;
        i_n = i == 4'd1 ? i : i - 4'd1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      we_n = 1'b0;
    end
  end
  // state and datapath registers, including the registered RAM port
  always_ff @(posedge pixelClk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      i <= 4'd0;
      j <= 4'd0;
      lfsr <= DEF_SEED;
      tile_i <= 8'd0;
      ram_we <= 1'b0;
      ram_addr <= 4'd0;
      ram_wdata <= 8'd0;
    end else begin
      state <= state_n;
      i <= i_n;
      j <= j_n;
      lfsr <= lfsr_n;
      tile_i <= tile_i_n;
      ram_we <= we_n;
      ram_addr <= addr_n;
      ram_wdata <= wd_n;
    end
  end
endmodule

// File: tb/tb_board_shuffler.sv
// tb_board_shuffler: checks board_shuffler against a Fisher-Yates reference model with an attached tile RAM
module tb_board_shuffler;
  logic pixelClk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] seed = 16'd0;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic ram_we, busy, done;
  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  logic [11:0] wlog [1024];
  int wcnt = 0;
  int total = 0, bad = 0;
  board_shuffler dut (
    .pixelClk(pixelClk), .resetn(resetn), .start(start), .abort(abort), .seed(seed),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .busy(busy), .done(done)
  );
  always #5 pixelClk = ~pixelClk;
  // synchronous tile RAM with one-cycle read latency, plus a log of every write
  always @(posedge pixelClk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wlog[wcnt[9:0]] <= {ram_addr, ram_wdata};
      wcnt <= wcnt + 1;
    end
    ram_rdata <= mem[ram_addr];
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge pixelClk);
    #1;
  endtask
  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction
  task automatic build_model(input logic [15:0] s);
    logic [15:0] l;
    logic [7:0] t;
    int j, m;
    for (int k = 0; k < 16; k++) ref_mem[k] = 8'(k / 2);
    l = s == 16'd0 ? 16'hACE1 : s;
    for (int i = 15; i >= 1; i--) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      do begin
        j = int'(l[3:0]) & m;
        l = step(l);
      end while (j > i);
      t = ref_mem[i];
      ref_mem[i] = ref_mem[j];
      ref_mem[j] = t;
    end
  endtask
  task automatic launch(input logic [15:0] s);
    seed = s;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic finish_run(input string tag);
    bit fin;
    int nd;
    fin = 1'b0;
    nd = 0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      tick;
      if (done) nd++;
      if (!busy && !done) fin = 1'b1;
    end
    if (!fin) chk({tag, " timeout"}, 0, 1);
    chk({tag, " done_pulses"}, nd, 1);
  endtask
  task automatic compare_ram(input string tag, input logic [15:0] s);
    int cnt [8];
    logic [4:0] hi;
    hi = 5'd0;
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    build_model(s);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s mem%0d", tag, k), int'(mem[k]), int'(ref_mem[k]));
      cnt[mem[k][2:0]]++;
      hi |= mem[k][7:3];
    end
    for (int k = 0; k < 8; k++) chk($sformatf("%s sym%0d_count", tag, k), cnt[k], 2);
    chk({tag, " high_bits"}, int'(hi), 0);
  endtask
  initial begin
    int base, nd;
    logic [15:0] s;
    tick;
    tick;
    chk("rst we", int'(ram_we), 0);
    chk("rst addr", int'(ram_addr), 0);
    chk("rst wdata", int'(ram_wdata), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst lfsr", int'(dut.lfsr), 16'hACE1);
    resetn = 1'b1;
    tick;
    tick;
    chk("post_rst idle busy", int'(busy), 0);
    chk("post_rst idle we", int'(ram_we), 0);
    launch(16'd0);
    chk("seed0 busy", int'(busy), 1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fill%0d", k), int'({ram_we, ram_addr, ram_wdata}), int'({1'b1, 4'(k), 8'(k / 2)}));
      tick;
    end
    chk("first_pick lfsr", int'(dut.lfsr), 16'hACE1);
    chk("first_pick we", int'(ram_we), 0);
    finish_run("seed0");
    compare_ram("seed0", 16'd0);
    launch(16'h1234);
    finish_run("s1234");
    compare_ram("s1234", 16'h1234);
    launch(16'hBEEF);
    repeat (4) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (11) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    finish_run("restart");
    compare_ram("restart", 16'hBEEF);
    base = wcnt;
    launch(16'h123F);
    finish_run("jeqi");
    chk("jeqi wr_i", int'(wlog[base + 16]), 12'hF07);
    chk("jeqi wr_j", int'(wlog[base + 17]), 12'hF07);
    compare_ram("jeqi", 16'h123F);
    launch(16'h5A5A);
    repeat (20) tick;
    chk("wr_i we", int'(ram_we), 1);
    chk("wr_i addr", int'(ram_addr), 15);
    resetn = 1'b0;
    #1;
    chk("async we", int'(ram_we), 0);
    chk("async addr", int'(ram_addr), 0);
    chk("async wdata", int'(ram_wdata), 0);
    chk("async busy", int'(busy), 0);
    chk("async done", int'(done), 0);
    #3;
    resetn = 1'b1;
    base = wcnt;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      nd += int'(done) + int'(busy);
    end
    chk("post_async activity", nd, 0);
    chk("post_async writes", wcnt - base, 0);
    launch(16'h7777);
    repeat (18) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort we", int'(ram_we), 0);
    base = wcnt;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      nd += int'(done) + int'(busy);
    end
    chk("post_abort activity", nd, 0);
    chk("post_abort writes", wcnt - base, 0);
    launch(16'h7777);
    chk("rebuild first write", int'({ram_we, ram_addr}), 5'h10);
    finish_run("rebuild");
    compare_ram("rebuild", 16'h7777);
    repeat (6) begin
      s = 16'($urandom);
      launch(s);
      finish_run($sformatf("rnd%04h", s));
      compare_ram($sformatf("rnd%04h", s), s);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
